regbank_sb: RTL and testbench

- Parametrised successor to the pipeline's 2-read/1-write register bank.
- Generalises data width, register count and read-port count, and enforces the architectural zero register on both reads and writes.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight producers.
- Sits between decode (read/issue) and writeback (write/clear).

---
 rtl/regbank_sb.sv | 105 ++++++++++
 tb/tb_regbank_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_sb.sv
// rtl/regbank_sb.sv - parametrised register bank with hard-wired x0 and pending-write scoreboard
// Optional write-through forwarding on the read ports: define REGBANK_BYPASS_EN.
module regbank_sb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       regwrite,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          datain,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_count
);

  localparam int NREG = 1 << ADDR_W;

  // x0 has no storage at all; reads of address 0 are forced to zero below.
  logic [DATA_W-1:0] bank [1:NREG-1];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              wr_en;
  logic              iss_en;

  assign wr_en  = regwrite && (waddr != '0);
  assign iss_en = issue_valid && (issue_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) begin
        bank[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_en && (waddr == ADDR_W'(r))) begin
          bank[r] <= datain;
        end
      end
    end
  end

  // Issue is applied after the writeback clear so a newer producer stays pending.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_en) begin
        busy_next[waddr] = 1'b0;
      end
      if (iss_en) begin
        busy_next[issue_addr] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    busy_count = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_count = busy_count + (ADDR_W+1)'(busy[r]);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (ra != '0) begin
        rd = bank[ra];
        rb = busy[ra];
      end
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (ra == waddr)) begin
        rd = datain;
        rb = 1'b0;
      end
`endif
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
    assign rbusy[i]                  = rb;
  end

endmodule

// File: tb/tb_regbank_sb.sv
// tb/tb_regbank_sb.sv - directed self-checking bench for regbank_sb
// Expectations adapt to REGBANK_BYPASS_EN when it is defined.
module tb_regbank_sb;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     regwrite;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        datain;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_count;

  int n_total;
  int n_bad;

  regbank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .regwrite   (regwrite),
    .waddr      (waddr),
    .datain     (datain),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    regwrite    = 1'b0;
    waddr       = '0;
    datain      = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    flush       = 1'b0;
  endtask

  // Advance one rising edge, then release all control inputs.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    regwrite = 1'b1;
    waddr    = a;
    datain   = d;
  endtask

  task automatic iss(input logic [ADDR_W-1:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    raddr   = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rd(5'd7, 5'd31);
    check("rst_held_rdata0", rdata[63:0], 64'h0);
    check("rst_held_rdata1", rdata[127:64], 64'h0);
    check("rst_held_count", 64'(busy_count), 64'h0);
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd(ADDR_W'(a), ADDR_W'(31 - a));
      check($sformatf("rst_rd0_r%0d", a), rdata[63:0], 64'h0);
      check($sformatf("rst_rd1_r%0d", 31 - a), rdata[127:64], 64'h0);
      check($sformatf("rst_busy_r%0d", a), 64'(rbusy), 64'h0);
    end
    check("rst_count", 64'(busy_count), 64'h0);

    // Reset asserted while a write is being presented, and clears earlier data.
    wr(5'd6, 64'h55);
    step();
    rd(5'd6, 5'd0);
    check("r6_written", rdata[63:0], 64'h55);
    iss(5'd6);
    step();
    check("r6_busy_pre_rst", 64'(busy_count), 64'h1);
    wr(5'd5, 64'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    rd(5'd6, 5'd5);
    check("async_rst_r6", rdata[63:0], 64'h0);
    check("async_rst_count", 64'(busy_count), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    rd(5'd5, 5'd6);
    check("midwr_rst_r5", rdata[63:0], 64'h0);
    check("midwr_rst_r6", rdata[127:64], 64'h0);

    // x0 writes and issues are dropped.
    wr(5'd0, 64'h1234);
    step();
    rd(5'd0, 5'd0);
    check("r0_write_dropped", rdata[63:0], 64'h0);
    iss(5'd0);
    step();
    check("r0_issue_count", 64'(busy_count), 64'h0);
    check("r0_issue_rbusy", 64'(rbusy), 64'h0);

    // Both ports reading the same register.
    wr(5'd7, 64'hA5A5);
    step();
    rd(5'd7, 5'd7);
    check("r7_port0", rdata[63:0], 64'hA5A5);
    check("r7_port1", rdata[127:64], 64'hA5A5);
    check("r7_nonbusy_wb", 64'(busy_count), 64'h0);

    // Scoreboard set, same-cycle set+clear, then clear.
    iss(5'd3);
    step();
    rd(5'd3, 5'd7);
    check("r3_busy", 64'(rbusy), 64'b01);
    check("r3_count", 64'(busy_count), 64'h1);
    iss(5'd3);
    wr(5'd3, 64'h33);
    step();
    rd(5'd3, 5'd3);
    check("r3_set_wins", 64'(rbusy), 64'b11);
    check("r3_set_wins_cnt", 64'(busy_count), 64'h1);
    check("r3_data_33", rdata[63:0], 64'h33);
    wr(5'd3, 64'h44);
    step();
    check("r3_cleared", 64'(rbusy), 64'b00);
    check("r3_clr_count", 64'(busy_count), 64'h0);
    check("r3_data_44", rdata[127:64], 64'h44);

    // Flush beats a same-cycle issue; the data write still lands.
    iss(5'd1);
    step();
    iss(5'd2);
    step();
    iss(5'd4);
    step();
    rd(5'd2, 5'd4);
    check("three_busy_cnt", 64'(busy_count), 64'h3);
    check("r2_r4_busy", 64'(rbusy), 64'b11);
    flush = 1'b1;
    iss(5'd9);
    wr(5'd11, 64'h99);
    step();
    rd(5'd9, 5'd11);
    check("flush_count", 64'(busy_count), 64'h0);
    check("flush_r9_rbusy", 64'(rbusy), 64'b00);
    check("flush_r11_data", rdata[127:64], 64'h99);

    // Re-issue does not count up; a single writeback clears it.
    iss(5'd12);
    step();
    iss(5'd12);
    step();
    check("reissue_count", 64'(busy_count), 64'h1);
    wr(5'd12, 64'hC);
    step();
    check("reissue_clear", 64'(busy_count), 64'h0);

    // Same-cycle write and read of r10 (issue alongside must not alter the read).
    wr(5'd10, 64'h10);
    step();
    wr(5'd10, 64'h77);
    iss(5'd10);
    rd(5'd10, 5'd0);
`ifdef REGBANK_BYPASS_EN
    check("r10_same_cyc", rdata[63:0], 64'h77);
`else
    check("r10_same_cyc", rdata[63:0], 64'h10);
`endif
    check("r10_same_rbusy", 64'(rbusy), 64'b00);
    check("r10_port1_r0", rdata[127:64], 64'h0);
    step();
    rd(5'd10, 5'd31);
    check("r10_next_cyc", rdata[63:0], 64'h77);
    check("r10_busy_next", 64'(rbusy), 64'b01);
    check("r10_count_next", 64'(busy_count), 64'h1);
    check("r31_untouched", rdata[127:64], 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
